motor_iface_translator_filtered: RTL and testbench

- Parametrised successor of the flat/structured motor interface translator, for N_MOTORS channels.
- Inputs from the motor drivers are synchronised into the local clock domain. Feedback switches are debounced, and power-fail indications are latched until cleared.
- Driver control outputs are registered, masked, and forced to a safe state on enable-mask or latched fail.
- Sits between the motor pin-level bundle (pl_*) and the structured per-motor status/control records in the controller clock domain.

---
 rtl/motor_iface_translator_filtered_if.sv | 40 ++++
 rtl/motor_iface_translator_filtered.sv | 125 ++++++++++++
 tb/tb_motor_iface_translator_filtered.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/motor_iface_translator_filtered_if.sv
// Pin-level and structured per-motor signal bundle for the motor interface translator.
// The controller side (master) drives the raw pins and control records; the translator (slave) drives the results.
interface motor_iface_translator_filtered_if #(
  parameter int N_MOTORS = 16
);
  logic [N_MOTORS-1:0] pl_pfail_i;
  logic [N_MOTORS-1:0] pl_sw_outa_i;
  logic [N_MOTORS-1:0] pl_sw_outb_i;
  logic [N_MOTORS-1:0] step_boost_i;
  logic [N_MOTORS-1:0] step_dir_i;
  logic [N_MOTORS-1:0] step_deactivate_i;
  logic [N_MOTORS-1:0] step_out_i;
  logic [N_MOTORS-1:0] motor_enable_mask_i;
  logic [N_MOTORS-1:0] pfail_clear_i;
  logic [N_MOTORS-1:0] pl_boost_o;
  logic [N_MOTORS-1:0] pl_dir_o;
  logic [N_MOTORS-1:0] pl_en_o;
  logic [N_MOTORS-1:0] pl_clk_o;
  logic [N_MOTORS-1:0] oh_o;
  logic [N_MOTORS-1:0] step_pfail_o;
  logic [N_MOTORS-1:0] raw_switches_a_o;
  logic [N_MOTORS-1:0] raw_switches_b_o;
  logic [N_MOTORS-1:0] sw_change_o;

  modport master (
    output pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i,
    output step_boost_i, step_dir_i, step_deactivate_i, step_out_i,
    output motor_enable_mask_i, pfail_clear_i,
    input  pl_boost_o, pl_dir_o, pl_en_o, pl_clk_o, oh_o, step_pfail_o,
    input  raw_switches_a_o, raw_switches_b_o, sw_change_o
  );

  modport slave (
    input  pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i,
    input  step_boost_i, step_dir_i, step_deactivate_i, step_out_i,
    input  motor_enable_mask_i, pfail_clear_i,
    output pl_boost_o, pl_dir_o, pl_en_o, pl_clk_o, oh_o, step_pfail_o,
    output raw_switches_a_o, raw_switches_b_o, sw_change_o
  );
endinterface

// File: rtl/motor_iface_translator_filtered.sv
// Motor pin-level <-> structured record translator: synchronises driver feedback, debounces switches,
// latches power-fail and registers driver controls with a safe-state override.
module motor_iface_translator_filtered #(
  parameter int N_MOTORS             = 16,
  parameter int DEBOUNCE_CYCLES      = 1000,
  parameter bit AUTO_DISABLE_ON_FAIL = 1'b1
) (
  input logic                        clk_i,
  input logic                        rst_i,
  motor_iface_translator_filtered_if.slave bus
);

  localparam int NSW = 2 * N_MOTORS;

  // Switches are handled as one vector: bits [N-1:0] are switch A, [2N-1:N] are switch B.
  logic [NSW-1:0]      sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [N_MOTORS-1:0] pfail_s1_q, pfail_s1_d, pfail_s2_q, pfail_s2_d;
  logic [N_MOTORS-1:0] pfail_q, pfail_d;
  logic [N_MOTORS-1:0] sw_change_q, sw_change_d;
  logic [N_MOTORS-1:0] pl_boost_q, pl_boost_d, pl_dir_q, pl_dir_d;
  logic [N_MOTORS-1:0] pl_en_q, pl_en_d, pl_clk_q, pl_clk_d;
  logic [N_MOTORS-1:0] disable_c;
  logic [NSW-1:0]      sw_stable, sw_stable_nxt, sw_diff;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // The second synchroniser stage is the accepted value; its next value is the first stage.
      assign sw_stable     = sw_s2_q;
      assign sw_stable_nxt = sw_s1_q;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0]  cnt_q [NSW];
      logic [CW-1:0]  cnt_d [NSW];
      logic [NSW-1:0] stable_q, stable_d;

      always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        stable_d = stable_q;
        for (int k = 0; k < NSW; k++) begin
          cnt_d[k] = '0;
          if (sw_s2_q[k] != stable_q[k]) begin
            if (cnt_q[k] == CNT_LAST) stable_d[k] = sw_s2_q[k];
            else                      cnt_d[k]    = cnt_q[k] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          stable_q <= '0;
          // NOTE: the counter array is control state, not storage, so it is reset along with everything else.
          for (int k = 0; k < NSW; k++) cnt_q[k] <= '0;
        end else begin
          // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
          stable_q <= stable_d;
          for (int k = 0; k < NSW; k++) cnt_q[k] <= cnt_d[k];
        end
      end

      assign sw_stable     = stable_q;
      assign sw_stable_nxt = stable_d;
    end
  endgenerate

  assign sw_diff = sw_stable_nxt ^ sw_stable;

  always_comb begin
    sw_s1_d    = {bus.pl_sw_outb_i, bus.pl_sw_outa_i};
    sw_s2_d    = sw_s1_q;
    pfail_s1_d = bus.pl_pfail_i;
    pfail_s2_d = pfail_s1_q;

    // Set dominates clear: a still-present synced fail re-asserts the latch.
    pfail_d = pfail_s2_q | (pfail_q & ~bus.pfail_clear_i);

    // Pulse appears together with the newly accepted switch value.
    sw_change_d = sw_diff[N_MOTORS-1:0] | sw_diff[NSW-1:N_MOTORS];

    disable_c = bus.step_deactivate_i | ~bus.motor_enable_mask_i
              | ({N_MOTORS{AUTO_DISABLE_ON_FAIL}} & pfail_q);
    pl_en_d    = disable_c;
    pl_clk_d   = bus.step_out_i & ~disable_c;
    pl_dir_d   = bus.step_dir_i;
    pl_boost_d = bus.step_boost_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      pfail_s1_q  <= '0;
      pfail_s2_q  <= '0;
      pfail_q     <= '0;
      sw_change_q <= '0;
      pl_en_q     <= '1;
      pl_clk_q    <= '0;
      pl_dir_q    <= '0;
      pl_boost_q  <= '0;
    end else begin
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      pfail_s1_q  <= pfail_s1_d;
      pfail_s2_q  <= pfail_s2_d;
      pfail_q     <= pfail_d;
      sw_change_q <= sw_change_d;
      pl_en_q     <= pl_en_d;
      pl_clk_q    <= pl_clk_d;
      pl_dir_q    <= pl_dir_d;
      pl_boost_q  <= pl_boost_d;
    end
  end

  assign bus.pl_boost_o       = pl_boost_q;
  assign bus.pl_dir_o         = pl_dir_q;
  assign bus.pl_en_o          = pl_en_q;
  assign bus.pl_clk_o         = pl_clk_q;
  assign bus.oh_o             = '0;
  assign bus.step_pfail_o     = pfail_q;
  assign bus.raw_switches_a_o = sw_stable[N_MOTORS-1:0];
  assign bus.raw_switches_b_o = sw_stable[NSW-1:N_MOTORS];
  assign bus.sw_change_o      = sw_change_q;

endmodule

// File: tb/tb_motor_iface_translator_filtered.sv
// Directed bench: one translator with a 4-cycle debounce and one in bypass, sharing clock and reset.
module tb_motor_iface_translator_filtered;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  motor_iface_translator_filtered_if #(.N_MOTORS(16)) b4 ();
  motor_iface_translator_filtered_if #(.N_MOTORS(16)) b0 ();

  motor_iface_translator_filtered #(
    .N_MOTORS(16), .DEBOUNCE_CYCLES(4), .AUTO_DISABLE_ON_FAIL(1'b1)
  ) dut (.clk_i(clk), .rst_i(rst), .bus(b4.slave));

  motor_iface_translator_filtered #(
    .N_MOTORS(16), .DEBOUNCE_CYCLES(0), .AUTO_DISABLE_ON_FAIL(1'b1)
  ) dut_bp (.clk_i(clk), .rst_i(rst), .bus(b0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pats [4];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    pats     = '{16'h00ff, 16'ha5a5, 16'h5a5a, 16'h1234};

    rst = 1'b1;
    b4.pl_pfail_i = '0; b4.pl_sw_outa_i = '0; b4.pl_sw_outb_i = '0;
    b4.step_boost_i = '0; b4.step_dir_i = '0; b4.step_deactivate_i = '0;
    b4.step_out_i = '0; b4.motor_enable_mask_i = 16'hffff; b4.pfail_clear_i = '0;
    b0.pl_pfail_i = '0; b0.pl_sw_outa_i = '0; b0.pl_sw_outb_i = '0;
    b0.step_boost_i = '0; b0.step_dir_i = '0; b0.step_deactivate_i = '0;
    b0.step_out_i = '0; b0.motor_enable_mask_i = 16'hffff; b0.pfail_clear_i = '0;

    // Reset state before any clock edge
    #1;
    chk("rst_en",    b4.pl_en_o,          16'hffff);
    chk("rst_clk",   b4.pl_clk_o,         16'h0000);
    chk("rst_pfail", b4.step_pfail_o,     16'h0000);
    chk("rst_oh",    b4.oh_o,             16'h0000);
    chk("rst_sw_a",  b4.raw_switches_a_o, 16'h0000);
    chk("rst_chg",   b4.sw_change_o,      16'h0000);
    step(); step();
    rst = 1'b0;
    b4.step_out_i = 16'hffff; b4.step_dir_i = 16'hffff; b4.step_boost_i = 16'hffff;
    step();
    chk("run_clk",   b4.pl_clk_o,   16'hffff);
    chk("run_en",    b4.pl_en_o,    16'h0000);
    chk("run_dir",   b4.pl_dir_o,   16'hffff);
    chk("run_boost", b4.pl_boost_o, 16'hffff);

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("arst_en",    b4.pl_en_o,    16'hffff);
    chk("arst_clk",   b4.pl_clk_o,   16'h0000);
    chk("arst_dir",   b4.pl_dir_o,   16'h0000);
    chk("arst_boost", b4.pl_boost_o, 16'h0000);
    step();
    chk("arst_hold_en",  b4.pl_en_o,  16'hffff);
    chk("arst_hold_clk", b4.pl_clk_o, 16'h0000);
    rst = 1'b0;
    #2;
    chk("rel_hold_clk", b4.pl_clk_o, 16'h0000);
    step();
    chk("rel_clk", b4.pl_clk_o, 16'hffff);
    chk("rel_en",  b4.pl_en_o,  16'h0000);

    // Control pass-through
    for (int i = 0; i < 4; i++) begin
      b4.step_out_i   = pats[i];
      b4.step_dir_i   = ~pats[i];
      b4.step_boost_i = pats[i] ^ 16'h0f0f;
      step();
      chk("pt_clk",   b4.pl_clk_o,   pats[i]);
      chk("pt_dir",   b4.pl_dir_o,   ~pats[i]);
      chk("pt_boost", b4.pl_boost_o, pats[i] ^ 16'h0f0f);
    end
    b4.motor_enable_mask_i = 16'hff7f;
    b4.step_out_i = 16'hffff; b4.step_dir_i = 16'hffff;
    step();
    chk("mask_clk", b4.pl_clk_o, 16'hff7f);
    chk("mask_en",  b4.pl_en_o,  16'h0080);
    chk("mask_dir", b4.pl_dir_o, 16'hffff);
    b4.step_dir_i = 16'h0000;
    step();
    chk("mask_dir0", b4.pl_dir_o, 16'h0000);
    chk("mask_en2",  b4.pl_en_o,  16'h0080);
    b4.motor_enable_mask_i = 16'hffff;
    b4.step_deactivate_i = 16'h0004;
    step();
    chk("deact_en",  b4.pl_en_o,  16'h0004);
    chk("deact_clk", b4.pl_clk_o, 16'hfffb);
    b4.step_deactivate_i = 16'h0000;
    step();
    chk("deact_off_en", b4.pl_en_o, 16'h0000);

    // Debounce, channel 3 switch A rises
    b4.pl_sw_outa_i = 16'h0008;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("deb_a",   b4.raw_switches_a_o, (e >= 6) ? 16'h0008 : 16'h0000);
      chk("deb_chg", b4.sw_change_o,      (e == 6) ? 16'h0008 : 16'h0000);
    end

    // Three-cycle glitch is rejected
    b4.pl_sw_outa_i = 16'h0000;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 3) b4.pl_sw_outa_i = 16'h0008;
      chk("glitch_a",   b4.raw_switches_a_o, 16'h0008);
      chk("glitch_chg", b4.sw_change_o,      16'h0000);
    end

    // Simultaneous A fall and B rise on channel 3 give one pulse
    b4.pl_sw_outa_i = 16'h0000;
    b4.pl_sw_outb_i = 16'h0008;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("sim_a",   b4.raw_switches_a_o, (e >= 6) ? 16'h0000 : 16'h0008);
      chk("sim_b",   b4.raw_switches_b_o, (e >= 6) ? 16'h0008 : 16'h0000);
      chk("sim_chg", b4.sw_change_o,      (e == 6) ? 16'h0008 : 16'h0000);
    end

    // Bypass instance, channel 0 switch B
    b0.pl_sw_outb_i = 16'h0001;
    step();
    chk("bp_b_e1", b0.raw_switches_b_o, 16'h0000);
    step();
    chk("bp_b_e2",   b0.raw_switches_b_o, 16'h0001);
    chk("bp_chg_e2", b0.sw_change_o,      16'h0001);
    step();
    chk("bp_chg_e3", b0.sw_change_o, 16'h0000);
    b0.pl_sw_outb_i = 16'h0000;
    step();
    chk("bp_fall_e1", b0.raw_switches_b_o, 16'h0001);
    step();
    chk("bp_fall_e2",  b0.raw_switches_b_o, 16'h0000);
    chk("bp_fchg_e2",  b0.sw_change_o,      16'h0001);

    // Power fail, channel 5: one-cycle raw pulse
    b4.pl_pfail_i = 16'h0020;
    step();
    chk("pf_e1", b4.step_pfail_o, 16'h0000);
    b4.pl_pfail_i = 16'h0000;
    step();
    chk("pf_e2", b4.step_pfail_o, 16'h0000);
    step();
    chk("pf_e3",    b4.step_pfail_o, 16'h0020);
    chk("pf_e3_en", b4.pl_en_o,      16'h0000);
    step();
    chk("pf_e4_en",  b4.pl_en_o,  16'h0020);
    chk("pf_e4_clk", b4.pl_clk_o, 16'hffdf);
    b4.pfail_clear_i = 16'h0020;
    step();
    chk("pf_clr", b4.step_pfail_o, 16'h0000);
    b4.pfail_clear_i = 16'h0000;
    step();
    chk("pf_clr_en",  b4.pl_en_o,  16'h0000);
    chk("pf_clr_clk", b4.pl_clk_o, 16'hffff);

    // Clear while raw fail still high is ignored
    b4.pl_pfail_i = 16'h0020;
    step(); step(); step();
    chk("pf_hold", b4.step_pfail_o, 16'h0020);
    b4.pfail_clear_i = 16'h0020;
    step();
    chk("pf_setwins", b4.step_pfail_o, 16'h0020);
    b4.pfail_clear_i = 16'h0000;
    b4.pl_pfail_i = 16'h0000;
    step(); step();
    chk("pf_still", b4.step_pfail_o, 16'h0020);
    b4.pfail_clear_i = 16'h0020;
    step();
    chk("pf_clr2", b4.step_pfail_o, 16'h0000);
    b4.pfail_clear_i = 16'h0000;
    step();

    // Independence: fail on channel 15 plus debounce on channel 0
    b4.pl_pfail_i   = 16'h8000;
    b4.pl_sw_outa_i = 16'h0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) b4.pl_pfail_i = 16'h0000;
      if (e == 3) chk("ind_pf", b4.step_pfail_o, 16'h8000);
      if (e == 4) begin
        chk("ind_en4",  b4.pl_en_o,  16'h8000);
        chk("ind_clk4", b4.pl_clk_o, 16'h7fff);
      end
      if (e == 6) begin
        chk("ind_a",   b4.raw_switches_a_o, 16'h0001);
        chk("ind_b",   b4.raw_switches_b_o, 16'h0008);
        chk("ind_chg", b4.sw_change_o,      16'h0001);
        chk("ind_en6", b4.pl_en_o,          16'h8000);
      end
      if (e == 7) chk("ind_chg7", b4.sw_change_o, 16'h0000);
    end
    chk("ind_bp_a", b0.raw_switches_a_o, 16'h0000);
    chk("ind_bp_pf", b0.step_pfail_o,    16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
